// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types for the pipelined adder family.
//   mode_e : operation selector, ADD = a+b+c_in, SUB = a+~b+1
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

endpackage : adder_pkg

// File: rtl/adder_pipe_stage.sv
// -----------------------------------------------------------------------------
// adder_pipe_stage
// One W-bit slice of the pipelined adder plus its stage register.
// The slice adds the low W bits of i_a/i_b with i_carry.  The operand
// vectors are shifted right by W on the way through so the next stage
// always finds its slice at bits [W-1:0]; the freshly computed sum slice
// is rotated into the top of the a-vector, so after the last stage the
// a-vector holds the complete sum in natural bit order.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   i_en            : global advance enable (low = pipeline stalled)
//   i_valid/o_valid : per-stage valid bit
//   i_carry/o_carry : carry into this slice / out of this slice
//   o_ovf           : signed overflow of this slice taken as the MSB slice
//   i_a/o_a         : remaining a slices, completed sum slices on top
//   i_b/o_b         : remaining b slices (already inverted for SUB)
// -----------------------------------------------------------------------------
module adder_pipe_stage #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_valid,
   input  logic         i_carry,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_valid,
   output logic         o_carry,
   output logic         o_ovf,
   output logic [N-1:0] o_a,
   output logic [N-1:0] o_b
);

   logic [W-1:0] w_sum;
   logic         w_cout;
   logic         w_cmsb;
   logic [N-1:0] w_a_nxt;
   logic [N-1:0] w_b_nxt;

   logic         r_valid;
   logic         r_carry;
   logic         r_ovf;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;

   adder_ripple #(.N(W)) u_add (
      .i_a     (i_a[W-1:0]),
      .i_b     (i_b[W-1:0]),
      .i_c     (i_carry),
      .o_sum   (w_sum),
      .o_c     (w_cout),
      .o_c_msb (w_cmsb)
   );

   // Single-stage configuration has no upper slices left to skew.
   if (W == N) begin : g_single
      assign w_a_nxt = w_sum;
      assign w_b_nxt = '0;
   end else begin : g_multi
      assign w_a_nxt = {w_sum, i_a[N-1:W]};
      assign w_b_nxt = {{W{1'b0}}, i_b[N-1:W]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
      end else if (i_en) begin
         r_valid <= i_valid;
         r_carry <= w_cout;
         r_ovf   <= w_cmsb ^ w_cout;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
      end
   end

   assign o_valid = r_valid;
   assign o_carry = r_carry;
   assign o_ovf   = r_ovf;
   assign o_a     = r_a;
   assign o_b     = r_b;

endmodule : adder_pipe_stage

// File: rtl/adder_ripple.sv
// -----------------------------------------------------------------------------
// adder_ripple
// Plain N-bit ripple-carry adder, purely combinational.
// Ports:
//   i_a, i_b  : N-bit operands
//   i_c       : carry into bit 0
//   o_sum     : N-bit sum
//   o_c       : carry out of bit N-1
//   o_c_msb   : carry into bit N-1 (lets callers derive signed overflow)
// -----------------------------------------------------------------------------
module adder_ripple #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_c,
   output logic [N-1:0] o_sum,
   output logic         o_c,
   output logic         o_c_msb
);

   logic [N:0] w_c;

   always_comb begin
      w_c    = '0;
      o_sum  = '0;
      w_c[0] = i_c;
      for (int unsigned i = 0; i < N; i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_c     = w_c[N];
   assign o_c_msb = w_c[N-1];

endmodule : adder_ripple

// File: rtl/adder_pipelined.sv
// -----------------------------------------------------------------------------
// adder_pipelined
// N-bit adder/subtractor split into STAGES slices of W = N/STAGES bits,
// one register stage per slice, valid/ready handshaking on both sides.
// Latency is STAGES cycles; one op per cycle while o_ready is high.  A
// stalled output (o_valid && !o_ready) freezes every stage at once.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_valid, i_ready  : upstream handshake (i_ready = !stall)
//   a, b, c_in, sub   : operands, carry-in (add only), subtract select
//   o_valid, o_ready  : downstream handshake
//   sum, c_out        : result modulo 2^N, carry out (SUB: 1 = no borrow)
//   overflow          : signed overflow
// -----------------------------------------------------------------------------
module adder_pipelined
   import adder_pkg::*;
#(
   parameter int unsigned N      = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int unsigned W = (STAGES == 0) ? N : N / STAGES;

   if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
      $error("adder_pipelined: N must be a non-zero multiple of STAGES");
   end

   mode_e        w_mode;
   logic [N-1:0] w_b_eff;
   logic         w_cin;
   logic         w_stall;

   logic [N-1:0]      w_a     [0:STAGES];
   logic [N-1:0]      w_b     [0:STAGES];
   logic [STAGES:0]   w_valid;
   logic [STAGES:0]   w_carry;
   logic [STAGES-1:0] w_ovf;
   logic              w_unused;

   assign w_mode  = sub ? MODE_SUB : MODE_ADD;
   assign w_b_eff = (w_mode == MODE_SUB) ? ~b   : b;
   assign w_cin   = (w_mode == MODE_SUB) ? 1'b1 : c_in;

   assign w_stall = o_valid && !o_ready;
   assign i_ready = !w_stall;

   assign w_a[0]     = a;
   assign w_b[0]     = w_b_eff;
   assign w_valid[0] = i_valid;
   assign w_carry[0] = w_cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_pipe_stage #(
         .N (N),
         .W (W)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_en    (i_ready),
         .i_valid (w_valid[k]),
         .i_carry (w_carry[k]),
         .i_a     (w_a[k]),
         .i_b     (w_b[k]),
         .o_valid (w_valid[k+1]),
         .o_carry (w_carry[k+1]),
         .o_ovf   (w_ovf[k]),
         .o_a     (w_a[k+1]),
         .o_b     (w_b[k+1])
      );
   end

   assign o_valid  = w_valid[STAGES];
   assign sum      = w_a[STAGES];
   assign c_out    = w_carry[STAGES];
   assign overflow = w_ovf[STAGES-1];

   // Only the MSB slice's overflow is meaningful, and the b-vector is
   // fully consumed by the last stage.
   assign w_unused = ^{w_ovf, w_b[STAGES]};

endmodule : adder_pipelined

// File: tb/tb_adder_pipelined.sv
// -----------------------------------------------------------------------------
// tb_adder_pipelined
// Directed bench for adder_pipelined with N=32, STAGES=4.
// -----------------------------------------------------------------------------
module tb_adder_pipelined;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        c_in;
   logic        sub;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] sum;
   logic        c_out;
   logic        overflow;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   adder_pipelined #(
      .N      (32),
      .STAGES (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sub      (sub),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Reference: {overflow, c_out, sum}; overflow from operand/result signs.
   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mc, input logic ms);
      logic [31:0] be;
      logic [32:0] t;
      logic        ov;
      be = ms ? ~mb : mb;
      t  = {1'b0, ma} + {1'b0, be} + {32'd0, (ms ? 1'b1 : mc)};
      ov = (ma[31] == be[31]) && (t[31] != ma[31]);
      return {ov, t};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full output check: o_valid plus result fields.
   task automatic chk_out(input string tag, input logic [33:0] exp);
      chk({tag, ".o_valid"},  {31'd0, o_valid},  32'd1);
      chk({tag, ".sum"},      sum,               exp[31:0]);
      chk({tag, ".c_out"},    {31'd0, c_out},    {31'd0, exp[32]});
      chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp[33]});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts);
      i_valid = v;
      a       = ta;
      b       = tb;
      c_in    = tc;
      sub     = ts;
   endtask

   // One isolated op: not visible after 3 edges, visible after the 4th.
   task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                             input logic tc, input logic ts, input logic [33:0] exp);
      drive(1'b1, ta, tb, tc, ts);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      step();
      chk({tag, ".early"}, {31'd0, o_valid}, 32'd0);
      step();
      chk_out(tag, exp);
      step();
      chk({tag, ".drain"}, {31'd0, o_valid}, 32'd0);
   endtask

   logic [31:0] ra [8];
   logic [31:0] rb [8];
   logic        rc [8];
   logic        rs [8];
   logic [33:0] rexp [8];

   logic [31:0] pa [5];
   logic [31:0] pb [5];
   logic        pc [5];
   logic        ps [5];
   logic [33:0] pexp [5];

   initial begin
      rst     = 1'b0;
      o_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);

      // Reset state
      #1;
      chk("rst.o_valid",  {31'd0, o_valid},  32'd0);
      chk("rst.sum",      sum,               32'd0);
      chk("rst.c_out",    {31'd0, c_out},    32'd0);
      chk("rst.overflow", {31'd0, overflow}, 32'd0);
      chk("rst.i_ready",  {31'd0, i_ready},  32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Directed single ops with hand-computed results {ovf, c_out, sum}
      run_single("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
      run_single("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
      run_single("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
      run_single("add_cin",   32'h0000_FFFF, 32'h00FF_0001, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0100_0001});
      run_single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});

      // 8 back-to-back ops
      for (int i = 0; i < 8; i++) begin
         ra[i]   = $urandom;
         rb[i]   = $urandom;
         rc[i]   = 1'($urandom_range(0, 1));
         rs[i]   = 1'($urandom_range(0, 1));
         rexp[i] = model(ra[i], rb[i], rc[i], rs[i]);
      end
      for (int c = 0; c < 12; c++) begin
         if (c < 8) drive(1'b1, ra[c], rb[c], rc[c], rs[c]);
         else       drive(1'b0, '0, '0, 1'b0, 1'b0);
         step();
         if (c >= 3 && c < 11) chk_out($sformatf("b2b[%0d]", c - 3), rexp[c - 3]);
         else                  chk($sformatf("b2b.idle%0d", c), {31'd0, o_valid}, 32'd0);
      end

      // Stall: fill with p0..p3, hold p0 at the output for 5 edges with p4 offered
      pa[0] = 32'h1111_1111; pb[0] = 32'h2222_2222; pc[0] = 1'b0; ps[0] = 1'b0;
      pexp[0] = {1'b0, 1'b0, 32'h3333_3333};
      pa[1] = 32'h0000_0001; pb[1] = 32'h0000_0002; pc[1] = 1'b1; ps[1] = 1'b0;
      pexp[1] = {1'b0, 1'b0, 32'h0000_0004};
      pa[2] = 32'h0000_0010; pb[2] = 32'h0000_0010; pc[2] = 1'b0; ps[2] = 1'b1;
      pexp[2] = {1'b0, 1'b1, 32'h0000_0000};
      pa[3] = 32'h8000_0000; pb[3] = 32'h8000_0000; pc[3] = 1'b0; ps[3] = 1'b0;
      pexp[3] = {1'b1, 1'b1, 32'h0000_0000};
      pa[4] = 32'h0000_0000; pb[4] = 32'h0000_0001; pc[4] = 1'b1; ps[4] = 1'b1;
      pexp[4] = {1'b0, 1'b0, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, pa[i], pb[i], pc[i], ps[i]);
         step();
      end
      o_ready = 1'b0;
      drive(1'b1, pa[4], pb[4], pc[4], ps[4]);
      #1;
      chk("stall.i_ready0", {31'd0, i_ready}, 32'd0);
      chk_out("stall.hold0", pexp[0]);
      for (int s = 1; s <= 5; s++) begin
         step();
         chk($sformatf("stall.i_ready%0d", s), {31'd0, i_ready}, 32'd0);
         chk_out($sformatf("stall.hold%0d", s), pexp[0]);
      end
      o_ready = 1'b1;
      #1;
      chk("stall.release", {31'd0, i_ready}, 32'd1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) begin
         chk_out($sformatf("stall.out%0d", i), pexp[i]);
         step();
      end
      chk("stall.drain", {31'd0, o_valid}, 32'd0);

      // Reset with one result on the output and 3 ops in flight
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1234_5678 + 32'(i), 32'h0000_0001, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk_out("rstmid.pre", {1'b0, 1'b0, 32'h1234_5679});
      rst = 1'b0;
      #1;
      chk("rstmid.o_valid",  {31'd0, o_valid},  32'd0);
      chk("rstmid.sum",      sum,               32'd0);
      chk("rstmid.c_out",    {31'd0, c_out},    32'd0);
      chk("rstmid.overflow", {31'd0, overflow}, 32'd0);
      chk("rstmid.i_ready",  {31'd0, i_ready},  32'd1);
      step();
      step();
      rst = 1'b1;
      for (int s = 0; s < 5; s++) begin
         step();
         chk($sformatf("rstmid.quiet%0d", s), {31'd0, o_valid}, 32'd0);
      end
      run_single("rstmid.new", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_adder_pipelined

// File: doc/adder_pipelined.md
ADDER_PIPELINED -- requirements
Module: adder_pipelined

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning number of pipeline register stages; W = N/STAGES bits per slice.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  upstream presents an operation.
REQ-006 SHALL have port i_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have ports a, b  input  N  operands.
REQ-008 SHALL have port c_in  input  1  carry-in, used in add mode only.
REQ-009 SHALL have port sub  input  1  0 = a+b+c_in, 1 = a-b (a + ~b + 1).
REQ-010 SHALL have port o_valid  output  1  sum/flags hold a valid result.
REQ-011 SHALL have port o_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port sum  output  N  result, modulo 2^N.
REQ-013 SHALL have port c_out  output  1  carry out of bit N-1 (in sub mode: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  signed overflow (carry into bit N-1 XOR carry out of bit N-1).

Function
REQ-015 SHALL elaborate only when N % STAGES == 0 and STAGES >= 1; otherwise elaboration error.
REQ-016 SHALL accept an operation on a rising edge where i_valid && i_ready.
REQ-017 SHALL compute slice k (bits [k*W +: W]) between register k and k+1, using the carry registered from slice k-1 (slice 0 uses effective carry-in).
REQ-018 SHALL skew operands: unconsumed upper slices of a, b (b already inverted in sub mode) travel with the carry; completed lower sum slices travel forward unchanged.
REQ-019 SHALL present sum, c_out, overflow, o_valid directly from the final register stage (no combinational path from inputs to these outputs).
REQ-020 SHALL have latency exactly STAGES cycles: result of an op accepted at edge t is on outputs after edge t+STAGES-1, with o_valid=1, absent stall.
REQ-021 SHALL sustain throughput of one op per cycle while o_ready=1.
REQ-022 SHALL stall globally: stall = o_valid && !o_ready; i_ready = !stall (combinational); while stall, no register changes.
REQ-023 SHALL hold sum, c_out, overflow stable while o_valid=1 and o_ready=0.
REQ-024 SHALL let bubbles propagate (per-stage valid bit); bubbles are not collapsed.
REQ-025 SHALL preserve operation order; no op duplicated or dropped.
REQ-026 SHALL ignore c_in when sub=1.

Reset
REQ-027 SHALL, on rst low, immediately clear all stage valid bits, o_valid=0, sum=0, c_out=0, overflow=0, regardless of clock.
REQ-028 SHALL discard in-flight operations on reset mid-operation; none appear after release.
REQ-029 SHALL drive i_ready=1 during and after reset (o_valid=0 implies no stall).

Structure
REQ-030 SHALL place the mode typedef (ADD/SUB enum) in shared package adder_pkg; N, STAGES remain module parameters.
REQ-031 SHALL use one sub-module, adder_pipe_stage: one W-bit slice plus its stage register, reusing the team's N-bit ripple adder with N=W for slice arithmetic.
REQ-032 SHALL instantiate adder_pipe_stage STAGES times via a generate loop.

Verification (N=32, STAGES=4)
REQ-033 SHALL cover: add a=0xFFFFFFFF, b=0x1, c_in=0 -> 4 cycles later sum=0x00000000, c_out=1, overflow=0.
REQ-034 SHALL cover: sub a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, overflow=0.
REQ-035 SHALL cover: add a=0x7FFFFFFF, b=0x1, c_in=0 -> sum=0x80000000, c_out=0, overflow=1.
REQ-036 SHALL cover: 8 back-to-back random ops, o_ready=1 -> 8 consecutive o_valid cycles, results match model in order.
REQ-037 SHALL cover: o_ready=0 for 5 cycles while o_valid=1 -> i_ready=0, outputs unchanged; after release remaining results emerge, none lost.
REQ-038 SHALL cover: rst low with 3 ops in flight -> o_valid=0 same cycle; after release, no output until a new op completes 4 cycles after acceptance.
